// File: rtl/int2fp_pkg.sv
// Shared FP32 constants and the tagged result record carried by the converter pipeline.
package int2fp_pkg;
   localparam int FP32_W        = 32;
   localparam int FP32_EXP_BIAS = 127;
   localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;
   // Tag storage sized for the largest supported requester count (16).
   localparam int ID_MAX_W = 4;

   typedef struct packed {
      logic [FP32_W-1:0]   result;
      logic                overflow;
      logic                underflow;
      logic [ID_MAX_W-1:0] id;
   } fp32_tagged_t;
endpackage

// File: rtl/int2fp_share_ctrl_if.sv
// Requester-side and result-side handshake bundle of the shared int->fp32 converter.
interface int2fp_share_ctrl_if
   import int2fp_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][FP32_W-1:0] req_data;
   logic [N_REQ-1:0]             req_ready;
   logic                         out_valid;
   logic                         out_ready;
   logic [FP32_W-1:0]            out_result;
   logic [ID_W-1:0]              out_id;
   logic                         out_overflow;
   logic                         out_underflow;
   logic                         busy;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_result, out_id, out_overflow, out_underflow, busy
   );
   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_result, out_id, out_overflow, out_underflow, busy
   );
endinterface

// File: rtl/int_to_fp32.sv
// Combinational signed 32-bit integer to IEEE-754 single, round to nearest even.
module int_to_fp32
   import int2fp_pkg::*;
(
   input  logic [31:0]       a,
   output logic [FP32_W-1:0] result,
   output logic              overflow,
   output logic              underflow,
   output logic              exception
);
   logic        sign, guard, sticky, rnd;
   logic [31:0] mag, norm;
   logic [4:0]  msb;
   logic [23:0] mant_r;
   logic [7:0]  exp_r;

   always_comb begin
      sign = a[31];
      mag  = sign ? (~a + 32'd1) : a;
      msb  = '0;
      for (int i = 0; i < 32; i++)
         if (mag[i]) msb = 5'(i);
      norm   = mag << (5'd31 - msb);
      guard  = norm[7];
      sticky = |norm[6:0];
      rnd    = guard & (sticky | norm[8]);
      // A carry out of the mantissa bumps the exponent; the field is then all zeros.
      mant_r = {1'b0, norm[30:8]} + 24'(rnd);
      exp_r  = 8'(FP32_EXP_BIAS) + {3'b0, msb} + {7'b0, mant_r[23]};
      result    = norm[31] ? {sign, exp_r, mant_r[22:0]} : FP32_ZERO;
      overflow  = 1'b0;
      underflow = 1'b0;
      exception = guard | sticky;
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping at N-1.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = 1; k <= N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end
endmodule

// File: rtl/int2fp_share_ctrl.sv
// Round-robin sharing of one int->fp32 converter between N_REQ requesters.
// S1 holds the granted operand, S2 the tagged result behind a valid/ready port.
module int2fp_share_ctrl
   import int2fp_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   int2fp_share_ctrl_if.slave bus
);
   localparam int STAGES = 2;

   logic [STAGES:1]   vld_pipe;
   logic              adv1, adv2, gany, hs;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   gidx, rr_ptr, s1_id;
   logic [FP32_W-1:0] s1_data, cv_result;
   logic              cv_ovf, cv_udf, cv_exc;
   fp32_tagged_t      s2;
   logic              unused_bits;

   assign adv2 = !vld_pipe[2] | bus.out_ready;
   assign adv1 = !vld_pipe[1] | adv2;

   rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
      .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .idx(gidx), .any(gany)
   );

   assign bus.req_ready = grant & {N_REQ{adv1}};
   assign hs            = gany & adv1;

   int_to_fp32 u_cvt (
      .a(s1_data), .result(cv_result), .overflow(cv_ovf), .underflow(cv_udf), .exception(cv_exc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         rr_ptr   <= ID_W'(N_REQ - 1);
         s1_data  <= '0;
         s1_id    <= '0;
         s2       <= '0;
      end else begin
         if (adv1) begin
            vld_pipe[1] <= hs;
            if (hs) begin
               s1_data <= bus.req_data[gidx];
               s1_id   <= gidx;
               rr_ptr  <= gidx;
            end
         end
         if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1])
               s2 <= '{result: cv_result, overflow: cv_ovf, underflow: cv_udf, id: ID_MAX_W'(s1_id)};
         end
      end
   end

   assign bus.out_valid     = vld_pipe[2];
   assign bus.out_result    = s2.result;
   assign bus.out_id        = s2.id[ID_W-1:0];
   assign bus.out_overflow  = s2.overflow;
   assign bus.out_underflow = s2.underflow;
   assign bus.busy          = |vld_pipe;

   // Converter exception and spare tag bits are intentionally dropped.
   assign unused_bits = ^{cv_exc, s2.id};
endmodule
